// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared types and encodings for the iterative multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Matches the ALU decoder's operation64 flag
    localparam logic OP_MUL = 1'b1;
    localparam logic OP_DIV = 1'b0;

    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sign_fix
//  Purpose  : Conditional two's-complement negate (magnitude / sign restore).
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative signed MULT/DIV, one bit per cycle, results in HI/LO.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op64,
    input  logic             flush,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    localparam int CNTW = $clog2(WIDTH) + 1;

    state_t               state_q;
    logic [CNTW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     dvd_q;
    logic                 sa_q;
    logic                 sb_q;
    logic                 op_q;
    logic                 bz_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH:0]     w_div_sh;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH-1:0]     w_hi_res;
    logic [WIDTH-1:0]     w_lo_res;

    muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
        .val (srca),
        .neg (srca[WIDTH-1]),
        .res (w_a_mag)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
        .val (srcb),
        .neg (srcb[WIDTH-1]),
        .res (w_b_mag)
    );

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val (prod_q),
        .neg (sa_q ^ sb_q),
        .res (w_prod_fix)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
        .val (prod_q[WIDTH-1:0]),
        .neg (sa_q ^ sb_q),
        .res (w_quo_fix)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val (prod_q[2*WIDTH-1:WIDTH]),
        .neg (sa_q),
        .res (w_rem_fix)
    );

    // Multiply: prod_q = {accumulator, remaining multiplier bits}.
    // Divide:   prod_q = {partial remainder, dividend shifting into quotient}.
    assign w_mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                       + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign w_div_sh    = {prod_q, 1'b0};
    assign w_div_trial = w_div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};

    always_comb begin
        prod_d = prod_q;
        if (op_q == OP_MUL) begin
            prod_d = {w_mul_sum, prod_q[WIDTH-1:1]};
        end else if (!w_div_trial[WIDTH]) begin
            prod_d = {w_div_trial[WIDTH-1:0], w_div_sh[WIDTH-1:1], 1'b1};
        end else begin
            prod_d = w_div_sh[2*WIDTH-1:0];
        end
    end

    // Most-negative / -1 yields magnitude 2^(W-1); negating it is a no-op,
    // so the overflow result falls out without a special case.
    always_comb begin
        w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod_fix[WIDTH-1:0];
        if (op_q == OP_DIV) begin
            if (bz_q) begin
                w_hi_res = dvd_q;
                w_lo_res = {WIDTH{1'b1}};
            end else begin
                w_hi_res = w_rem_fix;
                w_lo_res = w_quo_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            opnd_q  <= '0;
            dvd_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            op_q    <= OP_DIV;
            bz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        op_q    <= op64;
                        sa_q    <= srca[WIDTH-1];
                        sb_q    <= srcb[WIDTH-1];
                        bz_q    <= (srcb == '0);
                        dvd_q   <= srca;
                        if (op64 == OP_MUL) begin
                            prod_q <= {{WIDTH{1'b0}}, w_b_mag};
                            opnd_q <= w_a_mag;
                        end else begin
                            prod_q <= {{WIDTH{1'b0}}, w_a_mag};
                            opnd_q <= w_b_mag;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q + CNTW'(1);
                        if (cnt_q == CNTW'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        hi_q   <= w_hi_res;
                        lo_q   <= w_lo_res;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op64  = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] srca  = '0;
    logic [W-1:0] srcb  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op64  (op64),
        .flush (flush),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after an edge; returns 1 time unit after edge E0.
    task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        op64  = op;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int edges, output int busy_cyc);
        edges    = -1;
        busy_cyc = 0;
        for (int n = 1; n <= limit; n++) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            if (done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int e, bc;
        issue(1'b1, 32'd7, 32'hFFFF_FFFD);
        wait_done(60, e, bc);
        tests++; if (e !== 33) begin fails++; $display("FAIL mult_latency: got %0d expected 33", e); end
        tests++; if (bc !== 33) begin fails++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_div();
        int e, bc;
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done(60, e, bc);
        tests++; if (e !== 33) begin fails++; $display("FAIL div_latency: got %0d expected 33", e); end
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_quo: got %h expected fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_rem: got %h expected ffffffff", hi); end
        @(posedge clk); #1;
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(60, e, bc);
        tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_quo: got %h expected 80000000", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_rem: got %h expected 00000000", hi); end
    endtask

    task automatic test_div_zero();
        int e, bc;
        @(posedge clk); #1;
        issue(1'b0, 32'd100, 32'd0);
        wait_done(60, e, bc);
        tests++; if (e !== 33) begin fails++; $display("FAIL divz_latency: got %0d expected 33", e); end
        tests++; if (hi !== 32'h0000_0064) begin fails++; $display("FAIL divz_hi: got %h expected 00000064", hi); end
        tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL divz_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_start_while_busy();
        int e, bc;
        issue(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (9) begin @(posedge clk); #1; end
        issue(1'b0, 32'd9, 32'd4);
        wait_done(60, e, bc);
        tests++; if (e !== 23) begin fails++; $display("FAIL busy_start_latency: got %0d expected 23", e); end
        tests++; if (hi !== 32'h3FFF_FFFF) begin fails++; $display("FAIL busy_start_hi: got %h expected 3fffffff", hi); end
        tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL busy_start_lo: got %h expected 00000001", lo); end
        wait_done(40, e, bc);
        tests++; if (e !== -1) begin fails++; $display("FAIL busy_start_ignored: got done after %0d edges expected none", e); end
    endtask

    task automatic test_flush();
        int e, bc;
        issue(1'b1, 32'd5, 32'd5);
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b expected 0", busy); end
        wait_done(40, e, bc);
        tests++; if (e !== -1) begin fails++; $display("FAIL flush_no_done: got done after %0d edges expected none", e); end
        tests++; if (hi !== 32'h3FFF_FFFF) begin fails++; $display("FAIL flush_hi_kept: got %h expected 3fffffff", hi); end
        tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL flush_lo_kept: got %h expected 00000001", lo); end
        flush = 1'b1;
        issue(1'b1, 32'd2, 32'd2);
        flush = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_idle: got busy %b expected 0", busy); end
        issue(1'b0, 32'd9, 32'd4);
        wait_done(60, e, bc);
        tests++; if (lo !== 32'd2) begin fails++; $display("FAIL flush_div_quo: got %h expected 00000002", lo); end
        tests++; if (hi !== 32'd1) begin fails++; $display("FAIL flush_div_rem: got %h expected 00000001", hi); end
    endtask

    task automatic test_async_reset();
        int e, bc;
        @(posedge clk); #1;
        issue(1'b1, 32'd9, 32'd9);
        repeat (11) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL areset_done: got %b expected 0", done); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL areset_hi: got %h expected 00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL areset_lo: got %h expected 00000000", lo); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 32'd3, 32'd4);
        wait_done(60, e, bc);
        tests++; if (e !== 33) begin fails++; $display("FAIL areset_mult_latency: got %0d expected 33", e); end
        tests++; if (lo !== 32'd12) begin fails++; $display("FAIL areset_mult_lo: got %h expected 0000000c", lo); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL areset_mult_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        @(posedge clk); #1;
        issue(1'b1, 32'd6, 32'hFFFF_FFF9);
        wait_done(60, e, bc);
        tests++; if (lo !== 32'hFFFF_FFD6) begin fails++; $display("FAIL b2b_mult_lo: got %h expected ffffffd6", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_mult_hi: got %h expected ffffffff", hi); end
        issue(1'b0, 32'hFFFF_FF9C, 32'd7);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
        wait_done(60, e, bc);
        tests++; if (e !== 33) begin fails++; $display("FAIL b2b_div_latency: got %0d expected 33", e); end
        tests++; if (lo !== 32'hFFFF_FFF2) begin fails++; $display("FAIL b2b_div_quo: got %h expected fffffff2", lo); end
        tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL b2b_div_rem: got %h expected fffffffe", hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_while_busy();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle signed multiply/divide unit. It is the execute-stage consumer of the ALU decoder's operation64 flag: MULT/DIV (funct 011000/011010) start it, and MFHI/MFLO read its HI/LO registers. It is iterative, one bit per cycle. The hazard unit stalls the pipeline on busy.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNTW, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op64  input  1  operation select, decoder encoding: 1 = multiply, 0 = divide
flush  input  1  abort the in-flight operation (pipeline kill)
srca  input  WIDTH  multiplicand / dividend (rs), signed
srcb  input  WIDTH  multiplier / divisor (rt), signed
busy  output  1  operation in flight; the hazard unit stalls MFHI/MFLO/MULT/DIV while busy=1
done  output  1  one-cycle pulse when HI/LO are updated
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; counter = 0; busy = 0; done = 0; hi = 0; lo = 0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on start=1 and flush=0.
    - Latch |srca| and |srcb|, the operand signs and op64; counter = 0.
  - CALC runs for exactly WIDTH cycles, one iteration per cycle, then goes to FIX.
    - Multiply: shift-add on a 2*WIDTH partial product.
    - Divide: restoring shift-subtract, giving a WIDTH-bit quotient and remainder.
  - FIX (1 cycle): apply sign correction, write hi/lo, assert done, go to IDLE.
- Latency:
  - start is sampled at edge E0.
  - hi/lo are written and done=1 after edge E0+WIDTH+1 (edge 33 for WIDTH=32).
  - busy=1 from after E0 until after E0+WIDTH+1; busy is low in the cycle done is high.
- Sign rules:
  - Product: negated (2*WIDTH two's complement) if the operand signs differ. hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Quotient: negative if the signs differ. Remainder: takes the sign of the dividend.
- Divide by zero (srcb=0): full latency as normal; hi = srca unmodified, lo = all ones; no sign fixup.
- Overflow case, most-negative / -1: lo = 0x80000000, hi = 0 (the magnitude quotient 2^31 is kept unsigned, with no negation).
- start while busy: ignored; the in-flight operation is unaffected.
- flush:
  - In CALC or FIX: return to IDLE next cycle; hi/lo unchanged; no done pulse; busy=0 next cycle.
  - flush and start together in IDLE: flush wins, nothing starts.
  - flush wins over FIX's write.
- hi/lo change only in FIX (or at reset). Reads are combinational from the registers, so MFHI/MFLO see the old values while busy.
- Back-to-back: a start in the cycle where done=1 is accepted (FSM is in IDLE).

Decomposition:
- Shared package muldiv_pkg:
  - state typedef (IDLE, CALC, FIX);
  - OP_MUL=1'b1, OP_DIV=1'b0 constants, matching the decoder's operation64 encoding;
  - funct constants FN_MULT=6'b011000, FN_DIV=6'b011010, FN_MFHI=6'b010000, FN_MFLO=6'b010010.
- One natural sub-module: muldiv_sign_fix.
  - Combinational magnitude/negate helper.
  - Used at operand latch and in FIX.

Test Plan:
1. MULT 7 x -3 -> after 33 edges: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
2. DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIV 100 / 0 -> after 33 edges: hi=0x00000064, lo=0xFFFFFFFF, single done pulse.
4. MULT 0x7FFFFFFF x 0x7FFFFFFF, then start DIV 9/4 at cycle 10 while busy -> the DIV is ignored; hi=0x3FFFFFFF, lo=0x00000001.
5. MULT 5x5 with flush at cycle 20 -> busy=0 next cycle, no done, hi/lo keep their prior values. Then start DIV 9/4 -> lo=2, hi=1.
6. Assert reset low mid-CALC (cycle 12) -> busy, done, hi, lo immediately 0. After release, MULT 3x4 -> lo=12, hi=0, done on edge 33.
